// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak slice-oriented datapath.
//   SLICE_W   : bits per 5x5 slice, bit index 5*y+x
//   COLS      : columns (x) per slice
//   idx()     : bit index of lane (x,y) inside a slice
//   theta_d() : theta column mix D[x] = c_cur[x-1] ^ c_prev[x+1]
//   expand()  : replicate a 5-bit column vector across all five rows
package keccak_pkg;

    localparam int unsigned SLICE_W = 25;
    localparam int unsigned COLS    = 5;
    localparam int unsigned ROWS    = 5;

    typedef enum logic [1:0] {
        S_FIRST,
        S_STREAM,
        S_FLUSH
    } theta_state_e;

    function automatic int unsigned idx(input int unsigned x, input int unsigned y);
        return COLS * y + x;
    endfunction

    // c_cur is the parity of slice z, c_prev the parity of slice z-1.
    function automatic logic [COLS-1:0] theta_d(input logic [COLS-1:0] c_cur,
                                                input logic [COLS-1:0] c_prev);
        logic [COLS-1:0] d;
        d = '0;
        for (int x = 0; x < COLS; x++) begin
            d[x] = c_cur[(x + COLS - 1) % COLS] ^ c_prev[(x + 1) % COLS];
        end
        return d;
    endfunction

    function automatic logic [SLICE_W-1:0] expand(input logic [COLS-1:0] d);
        logic [SLICE_W-1:0] s;
        s = '0;
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
                s[idx(x, y)] = d[x];
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/theta_col_parity.sv
// Column parity of one Keccak slice: parity[x] = XOR over y of slice[5*y+x].
//   slice  : input 5x5 slice
//   parity : per-column XOR reduction
module theta_col_parity
    import keccak_pkg::*;
(
    input  logic [SLICE_W-1:0] slice,
    output logic [COLS-1:0]    parity
);

    always_comb begin
        parity = '0;
        for (int x = 0; x < COLS; x++) begin
            for (int y = 0; y < ROWS; y++) begin
                parity[x] = parity[x] ^ slice[idx(x, y)];
            end
        end
    end

endmodule

// File: rtl/theta_slice_stream.sv
// Streaming Keccak theta stage, one 5x5 slice per handshake.
// Slice 0 of each frame is held back until the last slice has been seen, because
// its mix needs the parity of slice NUM_SLICES-1; output order is 1..NUM_SLICES-1, 0.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   in_valid/in_ready/in_slice    : input slice stream
//   out_valid/out_ready/out_slice : theta-mixed output stream
//   out_idx                       : z index of out_slice
//   out_last                      : marks the z=0 beat that closes a frame
//   frame_done                    : pulse on the accepted out_last beat
module theta_slice_stream
    import keccak_pkg::*;
#(
    parameter int unsigned NUM_SLICES = 64,
    parameter int unsigned IDX_W      = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SLICE_W-1:0] in_slice,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SLICE_W-1:0] out_slice,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_last,
    output logic               frame_done
);

    localparam logic [IDX_W-1:0] LAST_Z = IDX_W'(NUM_SLICES - 1);

    theta_state_e       state_q, state_d;
    logic [IDX_W-1:0]   z_q, z_d;
    logic [SLICE_W-1:0] slice0_q, slice0_d;
    logic [COLS-1:0]    c0_q, c0_d;
    logic [COLS-1:0]    c_prev_q, c_prev_d;
    logic               out_valid_q, out_valid_d;
    logic [SLICE_W-1:0] out_slice_q, out_slice_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;
    logic               out_last_q, out_last_d;

    logic [COLS-1:0]    c_in;
    logic               slot_free;
    logic               in_fire;
    logic               out_fire;

    theta_col_parity u_parity_in (
        .slice  (in_slice),
        .parity (c_in)
    );

    // The output register can take a new value when empty or draining this cycle.
    assign slot_free  = !out_valid_q || out_ready;
    assign in_ready   = slot_free && (state_q != S_FLUSH);
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid_q && out_ready;
    assign frame_done = out_fire && out_last_q;

    assign out_valid  = out_valid_q;
    assign out_slice  = out_slice_q;
    assign out_idx    = out_idx_q;
    assign out_last   = out_last_q;

    always_comb begin
        state_d     = state_q;
        z_d         = z_q;
        slice0_d    = slice0_q;
        c0_d        = c0_q;
        c_prev_d    = c_prev_q;
        out_valid_d = out_valid_q;
        out_slice_d = out_slice_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;

        if (out_fire) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_FIRST: begin
                if (in_fire) begin
                    slice0_d = in_slice;
                    c0_d     = c_in;
                    c_prev_d = c_in;
                    z_d      = IDX_W'(1);
                    state_d  = S_STREAM;
                end
            end
            S_STREAM: begin
                if (in_fire) begin
                    out_slice_d = in_slice ^ expand(theta_d(c_in, c_prev_q));
                    out_idx_d   = z_q;
                    out_last_d  = 1'b0;
                    out_valid_d = 1'b1;
                    c_prev_d    = c_in;
                    z_d         = z_q + IDX_W'(1);
                    if (z_q == LAST_Z) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // c_prev_q now holds the parity of slice NUM_SLICES-1.
                if (slot_free) begin
                    out_slice_d = slice0_q ^ expand(theta_d(c0_q, c_prev_q));
                    out_idx_d   = '0;
                    out_last_d  = 1'b1;
                    out_valid_d = 1'b1;
                    z_d         = '0;
                    state_d     = S_FIRST;
                end
            end
            default: begin
                state_d = S_FIRST;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FIRST;
            z_q         <= '0;
            slice0_q    <= '0;
            c0_q        <= '0;
            c_prev_q    <= '0;
            out_valid_q <= 1'b0;
            out_slice_q <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            z_q         <= z_d;
            slice0_q    <= slice0_d;
            c0_q        <= c0_d;
            c_prev_q    <= c_prev_d;
            out_valid_q <= out_valid_d;
            out_slice_q <= out_slice_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_theta_slice_stream.sv
module tb_theta_slice_stream;

    localparam int NS = 64;

    typedef struct packed {
        logic [5:0]  idx;
        logic [24:0] slice;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] in_slice;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] out_slice;
    logic [5:0]  out_idx;
    logic        out_last;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    exp_t        exp_q[$];
    logic [24:0] in_q[$];
    logic [24:0] frm[NS];

    theta_slice_stream #(
        .NUM_SLICES (NS),
        .IDX_W      (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_slice   (in_slice),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_slice  (out_slice),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Reference: straight from the theta definition, indices mod 5 and mod NS.
    function automatic logic [4:0] ref_par(input logic [24:0] s);
        logic [4:0] p;
        p = '0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                p[x] = p[x] ^ s[5*y + x];
        return p;
    endfunction

    function automatic logic [24:0] ref_out(input int z);
        logic [4:0]  cz;
        logic [4:0]  cm;
        logic [24:0] o;
        cz = ref_par(frm[z]);
        cm = ref_par(frm[(z + NS - 1) % NS]);
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                o[5*y + x] = frm[z][5*y + x] ^ cz[(x + 4) % 5] ^ cm[(x + 1) % 5];
        return o;
    endfunction

    task automatic load_frame();
        exp_t e;
        for (int z = 0; z < NS; z++) in_q.push_back(frm[z]);
        for (int k = 1; k <= NS; k++) begin
            e.idx   = 6'(k % NS);
            e.slice = ref_out(k % NS);
            e.last  = (k == NS);
            exp_q.push_back(e);
        end
    endtask

    // Scenario engine: feeds in_q, drains the DUT, pops exp_q on every output beat.
    task automatic run_stream(input int stall_start, input int stall_len, input int budget,
                              output int first_in, output int last_out,
                              output int n_out, output int n_done);
        int          cyc;
        logic        in_fire;
        logic        out_fire;
        logic        held_v;
        logic [24:0] held_s;
        logic [5:0]  held_i;
        exp_t        e;
        exp_t        got;
        first_in = -1; last_out = -1; n_out = 0; n_done = 0;
        held_v = 1'b0; held_s = '0; held_i = '0; cyc = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
            @(negedge clk);
            in_valid  = (in_q.size() > 0);
            in_slice  = in_valid ? in_q[0] : 25'h0;
            out_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
            #1;
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (held_v) begin
                total++;
                if (out_valid !== 1'b1 || out_slice !== held_s || out_idx !== held_i) begin
                    bad++;
                    $display("FAIL hold: got v=%b slice=%h idx=%0d want v=1 slice=%h idx=%0d",
                             out_valid, out_slice, out_idx, held_s, held_i);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b0) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_in_ready: got %b want 0", in_ready);
                end
            end
            if (out_fire) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_output: got idx=%0d slice=%h want none", out_idx, out_slice);
                end else begin
                    e   = exp_q.pop_front();
                    got = '{idx: out_idx, slice: out_slice, last: out_last};
                    if (got !== e) begin
                        bad++;
                        $display("FAIL output: got idx=%0d slice=%h last=%b want idx=%0d slice=%h last=%b",
                                 got.idx, got.slice, got.last, e.idx, e.slice, e.last);
                    end
                    total++;
                    if (frame_done !== e.last) begin
                        bad++;
                        $display("FAIL frame_done: got %b want %b", frame_done, e.last);
                    end
                end
                last_out = cyc;
                n_out++;
            end else begin
                total++;
                if (frame_done !== 1'b0) begin
                    bad++;
                    $display("FAIL frame_done_idle: got %b want 0", frame_done);
                end
            end
            if (frame_done === 1'b1) n_done++;
            held_v = (out_valid === 1'b1) && !out_ready;
            held_s = out_slice;
            held_i = out_idx;
            if (in_fire) begin
                void'(in_q.pop_front());
                if (first_in < 0) first_in = cyc;
            end
            cyc++;
        end
        total++;
        if (in_q.size() != 0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL timeout: got in_left=%0d exp_left=%0d want 0 0", in_q.size(), exp_q.size());
            in_q.delete();
            exp_q.delete();
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL drained: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_slice = '0; out_ready = 1'b1;
        #3;
        total++;
        if ({out_valid, out_slice, out_idx, out_last, frame_done} !== 34'h0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b s=%h i=%0d l=%b fd=%b want all 0",
                     out_valid, out_slice, out_idx, out_last, frame_done);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_frame();
        int fi, lo, no, nd;
        for (int z = 0; z < NS; z++) frm[z] = '0;
        load_frame();
        run_stream(-1, 0, 400, fi, lo, no, nd);
        total++;
        if (no != NS || nd != 1) begin
            bad++;
            $display("FAIL zero_counts: got beats=%0d done=%0d want 64 1", no, nd);
        end
    endtask

    // Expected values written out by hand, independent of the reference model.
    task automatic test_single_bit(input int pos, input logic [24:0] at_pos,
                                   input logic [24:0] at_zero);
        int   fi, lo, no, nd;
        exp_t e;
        for (int z = 0; z < NS; z++) in_q.push_back(z == pos ? 25'h0000001 : 25'h0);
        for (int k = 1; k <= NS; k++) begin
            e.idx   = 6'(k % NS);
            e.last  = (k == NS);
            e.slice = (k == NS) ? at_zero : (k == pos) ? at_pos : 25'h0;
            if (pos == 0 && k == 1) e.slice = at_pos;
            exp_q.push_back(e);
        end
        run_stream(-1, 0, 400, fi, lo, no, nd);
        total++;
        if (no != NS || nd != 1) begin
            bad++;
            $display("FAIL single_bit_counts: got beats=%0d done=%0d want 64 1", no, nd);
        end
    endtask

    task automatic test_backpressure();
        int fi, lo, no, nd;
        for (int z = 0; z < NS; z++) frm[z] = 25'($urandom());
        load_frame();
        run_stream(20, 10, 400, fi, lo, no, nd);
        total++;
        if (no != NS || nd != 1) begin
            bad++;
            $display("FAIL bp_counts: got beats=%0d done=%0d want 64 1", no, nd);
        end
    endtask

    task automatic test_back_to_back();
        int fi, lo, no, nd;
        for (int z = 0; z < NS; z++) frm[z] = 25'($urandom());
        load_frame();
        for (int z = 0; z < NS; z++) frm[z] = 25'($urandom());
        load_frame();
        run_stream(-1, 0, 400, fi, lo, no, nd);
        total++;
        if (no != 2 * NS || nd != 2 || (lo - fi) != 130) begin
            bad++;
            $display("FAIL throughput: got beats=%0d done=%0d span=%0d want 128 2 130",
                     no, nd, lo - fi);
        end
    endtask

    task automatic test_reset_mid_frame();
        int   fi, lo, no, nd;
        exp_t e;
        for (int z = 0; z < NS; z++) frm[z] = 25'($urandom());
        for (int z = 0; z < 19; z++) in_q.push_back(frm[z]);
        for (int z = 1; z < 19; z++) begin
            e.idx = 6'(z); e.slice = ref_out(z); e.last = 1'b0;
            exp_q.push_back(e);
        end
        run_stream(-1, 0, 100, fi, lo, no, nd);
        // 20th input beat, held in the output slot by out_ready=0.
        @(negedge clk);
        in_valid = 1'b1; in_slice = frm[19]; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b1 || out_idx !== 6'd19) begin
            bad++;
            $display("FAIL pre_reset: got v=%b idx=%0d want v=1 idx=19", out_valid, out_idx);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_idx !== 6'd0) begin
            bad++;
            $display("FAIL async_reset: got v=%b idx=%0d want v=0 idx=0", out_valid, out_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int z = 0; z < NS; z++) frm[z] = 25'($urandom());
        load_frame();
        run_stream(-1, 0, 400, fi, lo, no, nd);
        total++;
        if (no != NS || nd != 1) begin
            bad++;
            $display("FAIL post_reset_counts: got beats=%0d done=%0d want 64 1", no, nd);
        end
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_single_bit(0, 25'h1084210, 25'h0210843);
        test_single_bit(63, 25'h0210843, 25'h1084210);
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
